// File: rtl/calc_pkg.sv
// Shared calculator definitions: opcodes, cache capacity, loader FSM states.
package calc_pkg;

  localparam int CACHE_DEPTH = 32;
  localparam int LD_W        = 6;

  localparam logic [2:0] ADD    = 3'b000;
  localparam logic [2:0] ACC    = 3'b001;
  localparam logic [2:0] MAC    = 3'b010;
  localparam logic [2:0] NOP_OP = 3'b011;
  localparam logic [2:0] POPC   = 3'b100;
  localparam logic [2:0] NOT    = 3'b101;
  localparam logic [2:0] JMP    = 3'b110;
  localparam logic [2:0] BAD_OP = 3'b111;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  // Opcodes the calculator would ignore or misinterpret never reach it.
  function automatic logic is_reject(input logic [2:0] op);
    return (op == NOP_OP) || (op == BAD_OP);
  endfunction

endpackage

// File: rtl/calc_loader_fifo.sv
// Synchronous first-word-fall-through staging FIFO; DEPTH must be a power of 2.
module calc_loader_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp, rp;
  logic [AW:0]      cnt;
  logic             do_push, do_pop;

  assign full    = cnt == (AW+1)'(DEPTH);
  assign empty   = cnt == '0;
  assign rdata   = mem[rp];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= wdata;
  end

endmodule

// File: rtl/calc_loader.sv
// Stages instructions into the calculator cache, then runs it for run_cycles.
// Optional macro CALC_LOADER_OVF_CNT_EN adds the ovf_count output.
module calc_loader
  import calc_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int CACHE_DEPTH = calc_pkg::CACHE_DEPTH
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_opCode,
  input  logic [3:0]      in_value,
  input  logic            start,
  input  logic [7:0]      run_cycles,
  input  logic [9:0]      result,
  input  logic            overflow,
  input  logic            cacheFull,
  output logic            mode,
  output logic [2:0]      opCode,
  output logic [3:0]      value,
  output logic            busy,
  output logic            done,
  output logic [LD_W-1:0] loaded_count,
  output logic [LD_W-1:0] rejected_count,
  output logic [9:0]      last_result,
  output logic            ovf_seen
`ifdef CALC_LOADER_OVF_CNT_EN
  ,
  output logic [7:0]      ovf_count
`endif
);

  state_e      state, nxt;
  logic        alive, pending;
  logic [7:0]  run_len, cnt;
  logic        f_push, f_pop, f_full, f_empty;
  logic [6:0]  f_rdata;
  logic        xfer, bad, room, issue, go, first, ovf_smp;
  logic [1:0]  rej_inc;
  logic [6:0]  rej_sum;
  logic        unused_ok;

  // Cache occupancy is tracked locally; the calculator's flag is informational.
  assign unused_ok = cacheFull;

  calc_loader_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(7)) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (f_push),
    .wdata ({in_opCode, in_value}),
    .pop   (f_pop),
    .rdata (f_rdata),
    .full  (f_full),
    .empty (f_empty)
  );

  assign in_ready = alive & (state == IDLE) & ~f_full & ~pending;
  assign xfer     = in_valid & in_ready;
  assign bad      = is_reject(in_opCode);
  assign f_push   = xfer & ~bad;
  assign room     = loaded_count < LD_W'(CACHE_DEPTH);
  assign f_pop    = (state == IDLE) & ~f_empty;
  assign issue    = f_pop & room;
  assign go       = (state == IDLE) & pending & f_empty;
  // The calculator's overflow lags its execute by a cycle, so RUN cycle 1 shows stale state.
  assign first    = (state == RUN) & (cnt == run_len);
  assign ovf_smp  = ((state == RUN) & ~first) | (state == DRAIN);
  assign rej_inc  = {1'b0, xfer & bad} + {1'b0, f_pop & ~room};
  assign rej_sum  = {1'b0, rejected_count} + {5'b0, rej_inc};

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (go) nxt = (run_len == 8'd0) ? DRAIN : RUN;
      RUN:     if (cnt == 8'd1) nxt = DRAIN;
      DRAIN:   nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      alive          <= 1'b0;
      pending        <= 1'b0;
      run_len        <= '0;
      cnt            <= '0;
      mode           <= 1'b0;
      opCode         <= NOP_OP;
      value          <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      loaded_count   <= '0;
      rejected_count <= '0;
      last_result    <= '0;
      ovf_seen       <= 1'b0;
    end else begin
      state <= nxt;
      alive <= 1'b1;

      if ((state == IDLE) && start && !pending) begin
        pending <= 1'b1;
        run_len <= run_cycles;
      end else if (go) begin
        pending <= 1'b0;
      end

      if (go)                 cnt <= run_len;
      else if (state == RUN)  cnt <= cnt - 8'd1;

      mode   <= nxt == RUN;
      opCode <= issue ? f_rdata[6:4] : NOP_OP;
      value  <= issue ? f_rdata[3:0] : 4'd0;
      busy   <= nxt != IDLE;
      done   <= nxt == DONE;

      if (issue) loaded_count <= loaded_count + 1'b1;
      rejected_count <= (rej_sum > 7'd63) ? 6'd63 : rej_sum[5:0];

      if (go)           ovf_seen <= 1'b0;
      else if (ovf_smp) ovf_seen <= ovf_seen | overflow;

      if (state == DRAIN) last_result <= result;
    end
  end

`ifdef CALC_LOADER_OVF_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                      ovf_count <= '0;
    else if (go)                                     ovf_count <= '0;
    else if (ovf_smp && overflow && ovf_count != 8'hFF) ovf_count <= ovf_count + 8'd1;
  end
`endif

endmodule

// File: tb/tb_calc_loader.sv
// Scoreboard bench for calc_loader with a small behavioural calculator attached.
module tb_calc_loader;
  import calc_pkg::*;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       in_valid = 1'b0, in_ready;
  logic [2:0] in_opCode = '0;
  logic [3:0] in_value = '0;
  logic       start = 1'b0;
  logic [7:0] run_cycles = '0;
  logic [9:0] result;
  logic       overflow, cacheFull;
  logic       mode, busy, done, ovf_seen;
  logic [2:0] opCode;
  logic [3:0] value;
  logic [5:0] loaded_count, rejected_count;
  logic [9:0] last_result;
`ifdef CALC_LOADER_OVF_CNT_EN
  logic [7:0] ovf_count;
`endif

  calc_loader dut (
    .clk(clk), .reset(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_opCode(in_opCode), .in_value(in_value), .start(start), .run_cycles(run_cycles),
    .result(result), .overflow(overflow), .cacheFull(cacheFull),
    .mode(mode), .opCode(opCode), .value(value), .busy(busy), .done(done),
    .loaded_count(loaded_count), .rejected_count(rejected_count),
    .last_result(last_result), .ovf_seen(ovf_seen)
`ifdef CALC_LOADER_OVF_CNT_EN
    , .ovf_count(ovf_count)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0, errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Calculator: caches mode=0 instructions, runs them from index 0 each run.
  logic [2:0]  c_op  [64];
  logic [3:0]  c_val [64];
  int          ccount, pc, c_idx;
  logic        prev_mode, ovf;
  logic [9:0]  acc, c_a;
  logic [13:0] c_full;

  assign result    = acc;
  assign overflow  = ovf;
  assign cacheFull = (ccount == 32);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ccount <= 0; pc <= 0; prev_mode <= 1'b0; acc <= '0; ovf <= 1'b0;
    end else begin
      prev_mode <= mode;
      if (!mode && !is_reject(opCode) && ccount < 32) begin
        c_op[ccount]  <= opCode;
        c_val[ccount] <= value;
        ccount        <= ccount + 1;
      end
      if (mode) begin
        c_idx = prev_mode ? pc : 0;
        c_a   = prev_mode ? acc : 10'd0;
        c_full = 14'(c_a);
        if (c_idx < ccount) begin
          case (c_op[c_idx])
            ADD:     c_full = 14'(c_a) + 14'(c_val[c_idx]);
            MAC:     c_full = 14'(c_a) * 14'(c_val[c_idx]) + 14'(c_val[c_idx]);
            default: c_full = 14'(c_a);
          endcase
        end
        acc <= c_full[9:0];
        ovf <= c_full > 14'd1023;
        pc  <= c_idx + 1;
      end
    end
  end

  // Scoreboard
  typedef struct {
    logic [9:0] lr;
    logic       ov;
    logic [5:0] ld;
    logic [5:0] rej;
    int         cyc;
  } done_t;

  logic [6:0] iss_q [$];
  done_t      done_q [$];
  int         runcyc = 0;

  task automatic exp_done(input logic [9:0] lr, input logic ov, input logic [5:0] ld,
                          input logic [5:0] rej, input int cyc);
    done_t d;
    d.lr = lr; d.ov = ov; d.ld = ld; d.rej = rej; d.cyc = cyc;
    done_q.push_back(d);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      runcyc = 0;
    end else begin
      if (mode) runcyc++;
      if (!mode && opCode !== NOP_OP) begin
        if (iss_q.size() == 0) check("issue_extra", 32'(iss_q.size()), 1);
        else check("issue", {opCode, value}, iss_q.pop_front());
      end
      if (done) begin
        if (done_q.size() == 0) begin
          check("done_extra", 32'(done_q.size()), 1);
        end else begin
          done_t d;
          d = done_q.pop_front();
          check("done_last_result", last_result, d.lr);
          check("done_ovf_seen", ovf_seen, d.ov);
          check("done_loaded", loaded_count, d.ld);
          check("done_rejected", rejected_count, d.rej);
          check("done_mode_cycles", runcyc, d.cyc);
          check("done_cachefull", cacheFull, loaded_count == 6'd32);
        end
        runcyc = 0;
      end
    end
  end

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mode", mode, 0);
    check("rst_opcode", opCode, NOP_OP);
    check("rst_value", value, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_loaded", loaded_count, 0);
    check("rst_rejected", rejected_count, 0);
    check("rst_last_result", last_result, 0);
    check("rst_ovf_seen", ovf_seen, 0);
    iss_q.delete();
    done_q.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1 check("in_ready_after_rst", in_ready, 1);
  endtask

  task automatic push(input logic [2:0] op, input logic [3:0] v, input bit exp);
    int t = 0;
    @(negedge clk);
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      check("push_ready_timeout", in_ready, 1);
      return;
    end
    in_valid = 1'b1; in_opCode = op; in_value = v;
    if (exp) iss_q.push_back({op, v});
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic start_run(input logic [7:0] n);
    @(negedge clk);
    start = 1'b1; run_cycles = n;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < budget);
    if (!done) check("done_timeout", done, 1);
  endtask

  initial begin
    int n;
    apply_reset();

    // Two adds then a 2-cycle run
    push(ADD, 4'd5, 1'b1);
    push(ADD, 4'd3, 1'b1);
    exp_done(10'd8, 1'b0, 6'd2, 6'd0, 2);
    start_run(8'd2);
    check("in_ready_pending", in_ready, 0);
    wait_done(50, n);

    // Locally rejected opcodes
    push(BAD_OP, 4'd9, 1'b0);
    repeat (4) @(negedge clk);
    check("reject_bad_cnt", rejected_count, 1);
    check("reject_bad_loaded", loaded_count, 2);
    push(NOP_OP, 4'd0, 1'b0);
    repeat (3) @(negedge clk);
    check("reject_nop_cnt", rejected_count, 2);

    // Zero-length run
    apply_reset();
    exp_done(10'd0, 1'b0, 6'd0, 6'd0, 0);
    start_run(8'd0);
    wait_done(20, n);
    check("run0_latency", n, 3);
    @(negedge clk);
    check("done_pulse_width", done, 0);

    // Overflowing MAC chain: 15 -> 240 -> 3615 (wraps to 543)
    push(ADD, 4'd15, 1'b1);
    push(MAC, 4'd15, 1'b1);
    push(MAC, 4'd15, 1'b1);
    exp_done(10'd543, 1'b1, 6'd3, 6'd0, 3);
    start_run(8'd3);
    wait_done(50, n);
`ifdef CALC_LOADER_OVF_CNT_EN
    check("ovf_count_mac", ovf_count, 1);
`endif

    // Rerun one cycle: sticky flag must clear, stale overflow in cycle 1 ignored
    exp_done(10'd15, 1'b0, 6'd3, 6'd0, 1);
    start_run(8'd1);
    wait_done(50, n);
`ifdef CALC_LOADER_OVF_CNT_EN
    check("ovf_count_clear", ovf_count, 0);
`endif

    // Cache fill: 34 pushes, 32 issued
    apply_reset();
    for (int i = 0; i < 34; i++) push(ADD, 4'd1, i < 32);
    repeat (6) @(negedge clk);
    check("fill_loaded", loaded_count, 32);
    check("fill_rejected", rejected_count, 2);
    check("fill_cachefull", cacheFull, loaded_count == 6'd32);

    // Reset during cycle 3 of a 10-cycle run
    apply_reset();
    push(ADD, 4'd1, 1'b1);
    start_run(8'd10);
    n = 0;
    for (int t = 0; t < 40 && n < 3; t++) begin
      @(negedge clk);
      if (mode) n++;
    end
    check("abort_reached_cycle3", n, 3);
    #1 rst_n = 1'b0;
    #1;
    check("abort_mode", mode, 0);
    check("abort_opcode", opCode, NOP_OP);
    check("abort_busy", busy, 0);
    check("abort_in_ready", in_ready, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1 check("abort_in_ready_release", in_ready, 1);
    repeat (20) @(negedge clk);
    check("abort_idle_busy", busy, 0);

    check("issue_q_drained", 32'(iss_q.size()), 0);
    check("done_q_drained", 32'(done_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
